// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: steps each instruction FETCH->DECODE->EXEC/MEM->WB and drives datapath controls.
// Latency: R/addiu/subiu/sw 4 cycles, lw 5, beq/j 3 at zero wait; each memory wait cycle adds one.
// Backpressure: MemRead/MemWrite/IorD hold steady until mem_ready; no timeout. TRAP is sticky until rst.
//
// Ports: clk/rst (sync, active-high); OpCode from the IR; mem_ready completes the pending memory access.
// Outputs are Moore-decoded from State, except IRWrite/PCWrite in FETCH which follow mem_ready.
// InstrCount counts retired instructions (wraps); Illegal is the sticky bad-opcode trap.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OpCode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       State,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_EXEC_I   = 4'd7;
    localparam logic [3:0] S_R_WB     = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_I_WB     = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [5:0] OP_R     = 6'd4;
    localparam logic [5:0] OP_ADDIU = 6'd12;
    localparam logic [5:0] OP_SUBIU = 6'd13;
    localparam logic [5:0] OP_SW    = 6'd16;
    localparam logic [5:0] OP_LW    = 6'd17;
    localparam logic [5:0] OP_BEQ   = 6'd19;
    localparam logic [5:0] OP_J     = 6'd28;

    logic [3:0]       state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             retire;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        retire    = 1'b0;
        unique case (state_q)
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                // Dispatch straight off the live opcode; op_q only becomes valid next cycle.
                op_d = OpCode;
                case (OpCode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_ADDIU, OP_SUBIU: state_d = S_EXEC_I;
                    OP_SW, OP_LW:       state_d = S_MEM_ADDR;
                    OP_BEQ:             state_d = S_BRANCH;
                    OP_J:               state_d = S_JUMP;
                    default:            state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC_R: state_d = S_R_WB;
            S_EXEC_I: state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;   // unused codes 12..14
        endcase
        cnt_d     = retire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
        // Set together with the entry into TRAP so the flag and state code agree.
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = 2'b01;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b01;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (op_q == OP_SUBIU) ? 2'b00 : 2'b01;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_I_WB: RegWrite = 1'b1;
            default: ;
        endcase
    end

    assign State      = state_q;
    assign Illegal    = illegal_q;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (CNT_W=4 so counter wrap is reachable).
// Each cycle compares the full control word against a hand-written per-state table.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OpCode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;
    logic [3:0] InstrCount;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .State(State), .Illegal(Illegal),
        .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Control word packing: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
    //  RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,State,Illegal}
    function automatic logic [31:0] ev(input int st, input bit mr, input bit sub);
        logic pcw, pcc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, ill;
        logic [1:0] asb, aop, psrc;
        logic [3:0] s4;
        {pcw, pcc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        s4 = st[3:0];
        case (st)
            0:  begin mrd = 1; asb = 2'b01; aop = 2'b01; irw = mr; pcw = mr; end
            1:  begin asb = 2'b11; aop = 2'b01; end
            2:  begin asa = 1; asb = 2'b10; aop = 2'b01; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; asb = 2'b00; aop = 2'b10; end
            7:  begin asa = 1; asb = 2'b10; aop = sub ? 2'b00 : 2'b01; end
            8:  begin rw = 1; rdst = 1; end
            9:  begin asa = 1; pcc = 1; psrc = 2'b01; end
            10: begin pcw = 1; psrc = 2'b10; end
            11: begin rw = 1; end
            15: begin ill = 1; end
            default: ;
        endcase
        return {11'd0, pcw, pcc, iord, mrd, mwr, irw, rdst, m2r, rw, asa,
                asb, aop, psrc, s4, ill};
    endfunction

    function automatic logic [31:0] obs();
        return {11'd0, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                State, Illegal};
    endfunction

    // Apply inputs for one cycle, compare the control word, advance past the edge.
    task automatic cyc(input bit mr, input logic [5:0] op, input int st, input bit sub,
                       input string tag);
        mem_ready = mr;
        OpCode    = op;
        #2;
        chk(tag, obs(), ev(st, mr, sub));
        @(posedge clk);
        #1;
    endtask

    task automatic r_instr();
        cyc(1, 6'd4, 0, 0, "r_fetch");
        cyc(1, 6'd4, 1, 0, "r_decode");
        cyc(1, 6'd4, 6, 0, "r_exec");
        cyc(1, 6'd4, 8, 0, "r_wb");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; OpCode = 6'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state; FETCH holds while memory is not ready.
        cyc(0, 6'd0, 0, 0, "rst_fetch");
        chk("rst_cnt", 32'(InstrCount), 32'd0);
        cyc(0, 6'd0, 0, 0, "fetch_wait");

        // addiu; OpCode flips to 13 after DECODE and must not matter.
        cyc(1, 6'd12, 0, 0, "addiu_fetch");
        cyc(0, 6'd12, 1, 0, "addiu_decode");
        cyc(1, 6'd13, 7, 0, "addiu_exec");
        cyc(1, 6'd13, 11, 0, "addiu_wb");
        chk("addiu_cnt", 32'(InstrCount), 32'd1);

        // subiu
        cyc(1, 6'd13, 0, 0, "subiu_fetch");
        cyc(1, 6'd13, 1, 0, "subiu_decode");
        cyc(1, 6'd12, 7, 1, "subiu_exec");
        cyc(1, 6'd12, 11, 0, "subiu_wb");
        chk("subiu_cnt", 32'(InstrCount), 32'd2);

        // lw with three wait cycles in MEM_RD.
        cyc(1, 6'd17, 0, 0, "lw_fetch");
        cyc(1, 6'd17, 1, 0, "lw_decode");
        cyc(1, 6'd16, 2, 0, "lw_addr");
        cyc(0, 6'd16, 3, 0, "lw_wait0");
        cyc(0, 6'd16, 3, 0, "lw_wait1");
        cyc(0, 6'd16, 3, 0, "lw_wait2");
        cyc(1, 6'd16, 3, 0, "lw_rd");
        cyc(0, 6'd16, 4, 0, "lw_wb");
        cyc(0, 6'd0, 0, 0, "lw_back");
        chk("lw_cnt", 32'(InstrCount), 32'd3);

        // beq then j
        cyc(1, 6'd19, 0, 0, "beq_fetch");
        cyc(1, 6'd19, 1, 0, "beq_decode");
        cyc(1, 6'd19, 9, 0, "beq_branch");
        cyc(1, 6'd28, 0, 0, "j_fetch");
        cyc(1, 6'd28, 1, 0, "j_decode");
        cyc(1, 6'd28, 10, 0, "j_jump");
        chk("bj_cnt", 32'(InstrCount), 32'd5);

        // sw with one wait.
        cyc(1, 6'd16, 0, 0, "sw_fetch");
        cyc(1, 6'd16, 1, 0, "sw_decode");
        cyc(1, 6'd17, 2, 0, "sw_addr");
        cyc(0, 6'd17, 5, 0, "sw_wait");
        cyc(1, 6'd17, 5, 0, "sw_wr");
        chk("sw_cnt", 32'(InstrCount), 32'd6);

        // Reset while sw waits; mem_ready asserted alongside rst must not retire.
        cyc(1, 6'd16, 0, 0, "swr_fetch");
        cyc(1, 6'd16, 1, 0, "swr_decode");
        cyc(1, 6'd16, 2, 0, "swr_addr");
        cyc(0, 6'd16, 5, 0, "swr_wait");
        mem_ready = 1'b1;
        do_reset();
        cyc(0, 6'd16, 0, 0, "swr_after_rst");
        chk("swr_cnt", 32'(InstrCount), 32'd0);

        // Illegal opcode: trap is sticky and ignores later opcodes and mem_ready.
        cyc(1, 6'd63, 0, 0, "ill_fetch");
        cyc(1, 6'd63, 1, 0, "ill_decode");
        for (int i = 0; i < 20; i++) cyc(i[0], 6'd4, 15, 0, "trap_hold");
        chk("trap_cnt", 32'(InstrCount), 32'd0);
        do_reset();
        cyc(0, 6'd4, 0, 0, "trap_rst");

        // 16 R-type retirements wrap the 4-bit counter.
        for (int i = 0; i < 15; i++) r_instr();
        chk("wrap_15", 32'(InstrCount), 32'd15);
        r_instr();
        chk("wrap_0", 32'(InstrCount), 32'd0);
        cyc(0, 6'd0, 0, 0, "final_fetch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
